// File: rtl/button_bank.sv
// Debounced N-channel push-button front end with press/release/long-press pulses
// and a stretched active-high system reset driven by power-on or a long-press.
module button_bank #(
   parameter int N               = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int LONG_CYCLES     = 27000000,
   parameter int RST_CH          = 0,
   parameter int RST_STRETCH     = 16
) (
   input  logic         i_clk,
   input  logic         i_resetn,
   input  logic [N-1:0] i_btn_raw,
   output logic [N-1:0] o_level,
   output logic [N-1:0] o_press,
   output logic [N-1:0] o_release,
   output logic [N-1:0] o_long_press,
   output logic         o_sys_rst
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam int SW = $clog2(RST_STRETCH + 1);

   localparam logic [N-1:0]  RELEASED = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
   localparam logic [DW-1:0] DLAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HLAST    = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HMAX     = HW'(LONG_CYCLES);
   localparam logic [SW-1:0] SMAX     = SW'(RST_STRETCH);
   localparam logic [SW-1:0] SONE     = SW'(1);

   typedef enum logic {
      S_HOLD,
      S_IDLE
   } rst_state_t;

   logic [N-1:0] r_sync1;
   logic [N-1:0] r_sync2;
   logic [N-1:0] w_pressed;

   // Sync flops reset to the idle pin level so leaving reset never looks like an edge.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_sync1 <= RELEASED;
         r_sync2 <= RELEASED;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pressed = r_sync2 ^ RELEASED;

   for (genvar g = 0; g < N; g++) begin : g_ch
      logic          r_level;
      logic          r_press;
      logic          r_release;
      logic          r_longPress;
      logic [DW-1:0] r_dcnt;
      logic [HW-1:0] r_hcnt;

      // Any cycle agreeing with the current level throws away accumulated credit.
      always_ff @(posedge i_clk or negedge i_resetn) begin
         if (!i_resetn) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_dcnt    <= '0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_pressed[g] == r_level) begin
               r_dcnt <= '0;
            end else if (r_dcnt == DLAST) begin
               r_level   <= w_pressed[g];
               r_dcnt    <= '0;
               r_press   <= w_pressed[g];
               r_release <= ~w_pressed[g];
            end else begin
               r_dcnt <= r_dcnt + 1'b1;
            end
         end
      end

      // Hold counter saturates at LONG_CYCLES so the pulse fires only once per hold.
      always_ff @(posedge i_clk or negedge i_resetn) begin
         if (!i_resetn) begin
            r_hcnt      <= '0;
            r_longPress <= 1'b0;
         end else begin
            r_longPress <= 1'b0;
            if (!r_level) begin
               r_hcnt <= '0;
            end else if (r_hcnt < HMAX) begin
               r_hcnt      <= r_hcnt + 1'b1;
               r_longPress <= (r_hcnt == HLAST);
            end
         end
      end

      assign o_level[g]      = r_level;
      assign o_press[g]      = r_press;
      assign o_release[g]    = r_release;
      assign o_long_press[g] = r_longPress;
   end

   rst_state_t    r_state;
   logic [SW-1:0] r_scnt;
   logic          r_sysRst;

   // A long-press seen while already stretching restarts the stretch from the top.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state  <= S_HOLD;
         r_scnt   <= SMAX;
         r_sysRst <= 1'b1;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (o_long_press[RST_CH]) begin
                  r_scnt   <= SMAX;
                  r_sysRst <= 1'b1;
               end else if (r_scnt == SONE) begin
                  r_state  <= S_IDLE;
                  r_sysRst <= 1'b0;
               end else begin
                  r_scnt <= r_scnt - 1'b1;
               end
            end
            S_IDLE: begin
               r_sysRst <= 1'b0;
               if (o_long_press[RST_CH]) begin
                  r_state  <= S_HOLD;
                  r_scnt   <= SMAX;
                  r_sysRst <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_HOLD;
               r_scnt   <= SMAX;
               r_sysRst <= 1'b1;
            end
         endcase
      end
   end

   assign o_sys_rst = r_sysRst;

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: debounce latency, bounce rejection, long-press,
// stretched reset and its restart, and async reset mid-hold.
module tb_button_bank;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] btnRaw;
   logic [1:0] level, press, rel, longPress;
   logic       sysRst;

   logic [0:0] btn2;
   logic [0:0] level2, press2, rel2, longPress2;
   logic       sysRst2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   button_bank #(
      .N(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
      .RST_CH(0), .RST_STRETCH(3)
   ) dut (
      .i_clk(clk), .i_resetn(resetn), .i_btn_raw(btnRaw),
      .o_level(level), .o_press(press), .o_release(rel),
      .o_long_press(longPress), .o_sys_rst(sysRst)
   );

   // Active-high single-channel instance with a long stretch so a second
   // long-press can land while the first stretch is still running.
   button_bank #(
      .N(1), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
      .RST_CH(0), .RST_STRETCH(40)
   ) dut2 (
      .i_clk(clk), .i_resetn(resetn), .i_btn_raw(btn2),
      .o_level(level2), .o_press(press2), .o_release(rel2),
      .o_long_press(longPress2), .o_sys_rst(sysRst2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                           input logic [1:0] rls, input logic [1:0] lng, input logic srst);
      checkOutput({tag, ".level"}, level, lvl);
      checkOutput({tag, ".press"}, press, prs);
      checkOutput({tag, ".release"}, rel, rls);
      checkOutput({tag, ".long"}, longPress, lng);
      checkOutput({tag, ".sysrst"}, {1'b0, sysRst}, {1'b0, srst});
   endtask

   task automatic applyStimulus(input string tag, input int n, input logic [1:0] lvl,
                                input logic [1:0] prs, input logic [1:0] rls,
                                input logic [1:0] lng, input logic srst);
      repeat (n) begin
         tick();
         checkAll(tag, lvl, prs, rls, lng, srst);
      end
   endtask

   task automatic applyStimulus2(input string tag, input int n, input logic lvl, input logic prs,
                                 input logic rls, input logic lng, input logic srst);
      repeat (n) begin
         tick();
         checkOutput({tag, ".level"}, {1'b0, level2}, {1'b0, lvl});
         checkOutput({tag, ".press"}, {1'b0, press2}, {1'b0, prs});
         checkOutput({tag, ".release"}, {1'b0, rel2}, {1'b0, rls});
         checkOutput({tag, ".long"}, {1'b0, longPress2}, {1'b0, lng});
         checkOutput({tag, ".sysrst"}, {1'b0, sysRst2}, {1'b0, srst});
      end
   endtask

   initial begin
      resetn = 1'b1;
      btnRaw = 2'b11;
      btn2   = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checkAll("rst_async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("rst_hold", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

      // Power-on stretch: high for three cycles after release, then low.
      resetn = 1'b1;
      applyStimulus("por_high", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("por_low", 4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Clean press and release of channel 0.
      btnRaw[0] = 1'b0;
      applyStimulus("c0_wait", 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0_press", 1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      btnRaw[0] = 1'b1;
      applyStimulus("c0_held", 5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0_rel", 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      applyStimulus("c0_idle", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Bouncing channel 1 never gets four stable cycles.
      for (int i = 0; i < 13; i++) begin
         btnRaw[1] = ~btnRaw[1];
         applyStimulus("c1_bounce", 3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      end
      applyStimulus("c1_settle", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1_press", 1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);

      // Long hold on channel 1: one pulse 20 cycles after press, no reset.
      applyStimulus("c1_hold", 19, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1_long", 1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
      applyStimulus("c1_sat", 5, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      btnRaw[1] = 1'b1;
      applyStimulus("c1_relwait", 5, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1_rel", 1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);

      // Short hold on channel 1: released after 15 cycles, no long-press.
      btnRaw[1] = 1'b0;
      applyStimulus("c1s_wait", 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1s_press", 1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1s_hold", 9, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      btnRaw[1] = 1'b1;
      applyStimulus("c1s_hold2", 5, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c1s_rel", 1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
      applyStimulus("c1s_idle", 8, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Long hold on the reset channel stretches sys_rst for three cycles.
      btnRaw[0] = 1'b0;
      applyStimulus("c0l_wait", 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0l_press", 1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0l_hold", 19, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0l_long", 1, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
      applyStimulus("c0l_srst", 3, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("c0l_after", 5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      btnRaw[0] = 1'b1;
      applyStimulus("c0l_relwait", 5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("c0l_rel", 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);

      // Both channels together report in the same cycle.
      btnRaw = 2'b00;
      applyStimulus("both_wait", 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("both_press", 1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
      btnRaw = 2'b11;
      applyStimulus("both_held", 5, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("both_rel", 1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);

      // Second long-press inside the stretch restarts it (active-high instance).
      btn2 = 1'b1;
      applyStimulus2("d2_wait", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus2("d2_press", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus2("d2_hold", 19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus2("d2_long", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      btn2 = 1'b0;
      applyStimulus2("d2_relwait", 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus2("d2_rel", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      btn2 = 1'b1;
      applyStimulus2("d2_rewait", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus2("d2_repress", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus2("d2_rehold", 19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus2("d2_relong", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus2("d2_stretch", 40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus2("d2_end", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      btn2 = 1'b0;

      // Reset pulled mid-hold; pin still held afterwards restarts from scratch.
      btnRaw[0] = 1'b0;
      applyStimulus("mr_wait", 5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_press", 1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_hold", 10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      resetn = 1'b0;
      #1;
      checkAll("mr_async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("mr_inrst", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      resetn = 1'b1;
      applyStimulus("mr_stretch", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("mr_deb", 3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_press2", 1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_hold2", 19, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_long", 1, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
      applyStimulus("mr_srst", 3, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      applyStimulus("mr_after", 1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      btnRaw[0] = 1'b1;
      applyStimulus("mr_relwait", 5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      applyStimulus("mr_rel", 1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
